// File: rtl/operand_loader_if.sv
// operand_loader_if: button, switch and operand/status signals of the operand loader
interface operand_loader_if #(
    parameter int WIDTH = 4
);
    logic             KEY_N;
    logic             CLR_N;
    logic [WIDTH-1:0] SW_DATA;
    logic             SW_SIGNED;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             SIGNED_MODE;
    logic             VALID;
    logic             LOAD_PULSE;
    logic [1:0]       STATE;
    modport master (
        output KEY_N, CLR_N, SW_DATA, SW_SIGNED,
        input  X, Y, SIGNED_MODE, VALID, LOAD_PULSE, STATE
    );
    modport slave (
        input  KEY_N, CLR_N, SW_DATA, SW_SIGNED,
        output X, Y, SIGNED_MODE, VALID, LOAD_PULSE, STATE
    );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: debounced enter/clear buttons drive a capture FSM for an X/Y operand pair
module operand_loader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               MAX10_CLK1_50,
    input  logic               RST,
    operand_loader_if.slave    bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE_X = 2'b00, WAIT_Y = 2'b01, SHOW = 2'b10, BAD = 2'b11} state_t;
    logic [1:0]       s1_q, s2_q, vld_q, deb_q, deb_d, prev_q, arm_q, arm_d, evt_q, evt_d;
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];
    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic             sm_q, sm_d, valid_q, valid_d, load_q, load_d;
    logic             enter, clr;
    assign enter = evt_q[0];
    assign clr   = evt_q[1];
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (s2_q[i] == deb_q[i] || cnt_q[i] == LIM) ? '0 : cnt_q[i] + 1'b1;
            deb_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] == LIM) ? s2_q[i] : deb_q[i];
            // a button held through reset stays disarmed until a genuine released sample is seen
            arm_d[i] = arm_q[i] | (vld_q[1] & s2_q[i]);
            evt_d[i] = arm_q[i] & prev_q[i] & ~deb_q[i];
        end
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sm_d    = sm_q;
        valid_d = valid_q;
        load_d  = 1'b0;
        if (clr || state_q == BAD) begin
            state_d = IDLE_X;
            x_d     = '0;
            y_d     = '0;
            sm_d    = 1'b0;
            valid_d = 1'b0;
        end else if (enter) begin
            if (state_q == IDLE_X) begin
                x_d     = bus.SW_DATA;
                state_d = WAIT_Y;
            end else if (state_q == WAIT_Y) begin
                y_d     = bus.SW_DATA;
                sm_d    = bus.SW_SIGNED;
                valid_d = 1'b1;
                load_d  = 1'b1;
                state_d = SHOW;
            end else begin
                x_d     = bus.SW_DATA;
                valid_d = 1'b0;
                state_d = WAIT_Y;
            end
        end
    end
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            s1_q    <= '1;
            s2_q    <= '1;
            vld_q   <= '0;
            deb_q   <= '1;
            prev_q  <= '1;
            arm_q   <= '0;
            evt_q   <= '0;
            cnt_q   <= '{default: '0};
            state_q <= IDLE_X;
            x_q     <= '0;
            y_q     <= '0;
            sm_q    <= 1'b0;
            valid_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            s1_q    <= {bus.CLR_N, bus.KEY_N};
            s2_q    <= s1_q;
            vld_q   <= {vld_q[0], 1'b1};
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            arm_q   <= arm_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sm_q    <= sm_d;
            valid_q <= valid_d;
            load_q  <= load_d;
        end
    end
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.SIGNED_MODE = sm_q;
    assign bus.VALID       = valid_q;
    assign bus.LOAD_PULSE  = load_q;
    assign bus.STATE       = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed checks of debounce, capture sequencing, clear and reset behaviour
module tb_operand_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lp_cnt = 0;
    int   lp_consec = 0;
    logic lp_prev = 1'b0;
    int   lp_base;
    operand_loader_if #(.WIDTH(4)) bus ();
    operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .MAX10_CLK1_50(clk),
        .RST(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (bus.LOAD_PULSE === 1'b1) begin
            lp_cnt++;
            if (lp_prev) lp_consec++;
        end
        lp_prev = (bus.LOAD_PULSE === 1'b1);
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic press(input logic key, input logic clr, input int hold);
        bus.KEY_N = ~key;
        bus.CLR_N = ~clr;
        tick(hold);
        bus.KEY_N = 1'b1;
        bus.CLR_N = 1'b1;
        tick(10);
    endtask
    initial begin
        bus.KEY_N     = 1'b1;
        bus.CLR_N     = 1'b1;
        bus.SW_DATA   = 4'h0;
        bus.SW_SIGNED = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_x", 32'(bus.X), 0);
        chk("rst_y", 32'(bus.Y), 0);
        chk("rst_sm", 32'(bus.SIGNED_MODE), 0);
        chk("rst_valid", 32'(bus.VALID), 0);
        chk("rst_lp", 32'(bus.LOAD_PULSE), 0);
        chk("rst_state", 32'(bus.STATE), 0);
        tick(3);
        // enter press: capture latency window, then the Y capture
        bus.SW_DATA = 4'h5;
        bus.KEY_N   = 1'b0;
        tick(7);
        chk("x_before_window", 32'(bus.X), 0);
        tick(1);
        chk("x_latency", 32'(bus.X), 5);
        chk("state_wait_y", 32'(bus.STATE), 1);
        tick(2);
        bus.KEY_N = 1'b1;
        tick(10);
        lp_base     = lp_cnt;
        bus.SW_DATA = 4'hB;
        press(1'b1, 1'b0, 10);
        chk("pair_x", 32'(bus.X), 5);
        chk("pair_y", 32'(bus.Y), 4'hB);
        chk("pair_valid", 32'(bus.VALID), 1);
        chk("pair_state", 32'(bus.STATE), 2);
        chk("pair_sm", 32'(bus.SIGNED_MODE), 0);
        chk("pair_lp_count", 32'(lp_cnt - lp_base), 1);
        // switches toggled in SHOW with no presses
        bus.SW_SIGNED = 1'b1;
        bus.SW_DATA   = 4'hF;
        tick(5);
        bus.SW_DATA = 4'h3;
        tick(3);
        chk("show_x_hold", 32'(bus.X), 5);
        chk("show_y_hold", 32'(bus.Y), 4'hB);
        chk("show_sm_hold", 32'(bus.SIGNED_MODE), 0);
        chk("show_valid_hold", 32'(bus.VALID), 1);
        // glitch shorter than the debounce window
        lp_base = lp_cnt;
        press(1'b1, 1'b0, 3);
        chk("glitch_x", 32'(bus.X), 5);
        chk("glitch_state", 32'(bus.STATE), 2);
        chk("glitch_lp", 32'(lp_cnt - lp_base), 0);
        // clear from SHOW
        press(1'b0, 1'b1, 6);
        chk("clr_state", 32'(bus.STATE), 0);
        chk("clr_x", 32'(bus.X), 0);
        chk("clr_y", 32'(bus.Y), 0);
        chk("clr_valid", 32'(bus.VALID), 0);
        // long hold produces a single capture
        bus.SW_SIGNED = 1'b0;
        bus.SW_DATA   = 4'h7;
        bus.KEY_N     = 1'b0;
        tick(100);
        chk("hold_x", 32'(bus.X), 7);
        chk("hold_state", 32'(bus.STATE), 1);
        chk("hold_y", 32'(bus.Y), 0);
        bus.KEY_N = 1'b1;
        tick(10);
        chk("hold_state_after", 32'(bus.STATE), 1);
        // signed pair, then simultaneous enter and clear
        bus.SW_DATA   = 4'h9;
        bus.SW_SIGNED = 1'b1;
        press(1'b1, 1'b0, 6);
        chk("signed_sm", 32'(bus.SIGNED_MODE), 1);
        chk("signed_y_raw", 32'(bus.Y), 4'h9);
        chk("signed_state", 32'(bus.STATE), 2);
        press(1'b1, 1'b1, 6);
        chk("both_state", 32'(bus.STATE), 0);
        chk("both_x", 32'(bus.X), 0);
        chk("both_y", 32'(bus.Y), 0);
        chk("both_valid", 32'(bus.VALID), 0);
        chk("both_sm", 32'(bus.SIGNED_MODE), 0);
        // reset while the button is held in WAIT_Y
        bus.SW_SIGNED = 1'b0;
        bus.SW_DATA   = 4'h2;
        press(1'b1, 1'b0, 6);
        chk("pre_rst_x", 32'(bus.X), 2);
        chk("pre_rst_state", 32'(bus.STATE), 1);
        bus.SW_DATA = 4'hD;
        bus.KEY_N   = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_x", 32'(bus.X), 0);
        chk("mid_rst_state", 32'(bus.STATE), 0);
        chk("mid_rst_valid", 32'(bus.VALID), 0);
        tick(20);
        chk("held_rst_x", 32'(bus.X), 0);
        chk("held_rst_state", 32'(bus.STATE), 0);
        bus.KEY_N = 1'b1;
        tick(10);
        chk("release_rst_state", 32'(bus.STATE), 0);
        bus.SW_DATA = 4'h6;
        press(1'b1, 1'b0, 6);
        chk("repress_x", 32'(bus.X), 6);
        chk("repress_state", 32'(bus.STATE), 1);
        chk("lp_never_consecutive", 32'(lp_consec), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
